// File: rtl/soc_fpga_axi_m0_arbiter.sv
// Two-client arbiter and sequencer for the SoC AXI M0 master port; one transaction in flight.
// Define SOC_M0_ARB_FIXED_PRIO_EN for fixed priority (r0 wins ties) instead of round-robin.
module soc_fpga_axi_m0_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter logic [3:0]  AXI_CACHE = 4'b0011,
    parameter logic [2:0]  AXI_PROT  = 3'b000
) (
    input  logic                M0_ACLK,
    input  logic                M0_ARESET,
    input  logic                M0_ARESETN_I,
    input  logic                r0_cmd_valid,
    output logic                r0_cmd_ready,
    input  logic                r0_cmd_write,
    input  logic [ADDR_W-1:0]   r0_cmd_addr,
    input  logic [2:0]          r0_cmd_len,
    input  logic                r0_wr_valid,
    output logic                r0_wr_ready,
    input  logic [DATA_W-1:0]   r0_wr_data,
    input  logic [DATA_W/8-1:0] r0_wr_strb,
    output logic                r0_rd_valid,
    input  logic                r0_rd_ready,
    output logic [DATA_W-1:0]   r0_rd_data,
    output logic                r0_rd_last,
    output logic                r0_done,
    output logic [1:0]          r0_resp,
    input  logic                r1_cmd_valid,
    output logic                r1_cmd_ready,
    input  logic                r1_cmd_write,
    input  logic [ADDR_W-1:0]   r1_cmd_addr,
    input  logic [2:0]          r1_cmd_len,
    input  logic                r1_wr_valid,
    output logic                r1_wr_ready,
    input  logic [DATA_W-1:0]   r1_wr_data,
    input  logic [DATA_W/8-1:0] r1_wr_strb,
    output logic                r1_rd_valid,
    input  logic                r1_rd_ready,
    output logic [DATA_W-1:0]   r1_rd_data,
    output logic                r1_rd_last,
    output logic                r1_done,
    output logic [1:0]          r1_resp,
    output logic [ADDR_W-1:0]   M0_ARADDR,
    output logic [1:0]          M0_ARBURST,
    output logic [3:0]          M0_ARCACHE,
    output logic [3:0]          M0_ARID,
    output logic [7:0]          M0_ARLEN,
    output logic                M0_ARLOCK,
    output logic [2:0]          M0_ARPROT,
    output logic [2:0]          M0_ARSIZE,
    output logic                M0_ARVALID,
    input  logic                M0_ARREADY,
    output logic [ADDR_W-1:0]   M0_AWADDR,
    output logic [1:0]          M0_AWBURST,
    output logic [3:0]          M0_AWCACHE,
    output logic [3:0]          M0_AWID,
    output logic [7:0]          M0_AWLEN,
    output logic                M0_AWLOCK,
    output logic [2:0]          M0_AWPROT,
    output logic [2:0]          M0_AWSIZE,
    output logic                M0_AWVALID,
    input  logic                M0_AWREADY,
    output logic [DATA_W-1:0]   M0_WDATA,
    output logic [DATA_W/8-1:0] M0_WSTRB,
    output logic                M0_WLAST,
    output logic                M0_WVALID,
    input  logic                M0_WREADY,
    input  logic [3:0]          M0_BID,
    input  logic [1:0]          M0_BRESP,
    input  logic                M0_BVALID,
    output logic                M0_BREADY,
    input  logic [3:0]          M0_RID,
    input  logic [DATA_W-1:0]   M0_RDATA,
    input  logic [1:0]          M0_RRESP,
    input  logic                M0_RLAST,
    input  logic                M0_RVALID,
    output logic                M0_RREADY
);
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BRESP, RDATA} state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          len_q, len_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                grant_q, grant_d;
    logic [1:0]          racc_q, racc_d;
    logic                rerr_q, rerr_d;
    logic [1:0]          done_q, done_d;
    logic [1:0]          resp0_q, resp0_d;
    logic [1:0]          resp1_q, resp1_d;
`ifndef SOC_M0_ARB_FIXED_PRIO_EN
    logic                rr_last_q, rr_last_d;
`endif
    logic                win;
    logic                fin;
    logic [1:0]          fin_resp;
    logic [1:0]          rresp_max;
    logic                rid_bad;

    // Attributes are fixed or come straight from the latched command
    assign M0_ARADDR  = addr_q;
    assign M0_AWADDR  = addr_q;
    assign M0_ARLEN   = 8'(len_q);
    assign M0_AWLEN   = 8'(len_q);
    assign M0_ARSIZE  = 3'd3;
    assign M0_AWSIZE  = 3'd3;
    assign M0_ARBURST = 2'b01;
    assign M0_AWBURST = 2'b01;
    assign M0_ARLOCK  = 1'b0;
    assign M0_AWLOCK  = 1'b0;
    assign M0_ARCACHE = AXI_CACHE;
    assign M0_AWCACHE = AXI_CACHE;
    assign M0_ARPROT  = AXI_PROT;
    assign M0_AWPROT  = AXI_PROT;
    assign M0_ARID    = {3'b000, grant_q};
    assign M0_AWID    = {3'b000, grant_q};
    assign r0_done    = done_q[0];
    assign r1_done    = done_q[1];
    assign r0_resp    = resp0_q;
    assign r1_resp    = resp1_q;

    always_ff @(posedge M0_ACLK) begin
        if (M0_ARESET) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= 1'b0;
            racc_q    <= '0;
            rerr_q    <= 1'b0;
            done_q    <= '0;
            resp0_q   <= '0;
            resp1_q   <= '0;
`ifndef SOC_M0_ARB_FIXED_PRIO_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            racc_q    <= racc_d;
            rerr_q    <= rerr_d;
            done_q    <= done_d;
            resp0_q   <= resp0_d;
            resp1_q   <= resp1_d;
`ifndef SOC_M0_ARB_FIXED_PRIO_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        racc_d       = racc_q;
        rerr_d       = rerr_q;
        done_d       = '0;
        resp0_d      = resp0_q;
        resp1_d      = resp1_q;
`ifndef SOC_M0_ARB_FIXED_PRIO_EN
        rr_last_d    = rr_last_q;
`endif
        win          = 1'b0;
        fin          = 1'b0;
        fin_resp     = '0;
        rresp_max    = '0;
        rid_bad      = 1'b0;
        r0_cmd_ready = 1'b0;
        r1_cmd_ready = 1'b0;
        r0_wr_ready  = 1'b0;
        r1_wr_ready  = 1'b0;
        r0_rd_valid  = 1'b0;
        r1_rd_valid  = 1'b0;
        r0_rd_data   = '0;
        r1_rd_data   = '0;
        r0_rd_last   = 1'b0;
        r1_rd_last   = 1'b0;
        M0_ARVALID   = 1'b0;
        M0_AWVALID   = 1'b0;
        M0_WVALID    = 1'b0;
        M0_WDATA     = '0;
        M0_WSTRB     = '0;
        M0_WLAST     = 1'b0;
        M0_BREADY    = 1'b0;
        M0_RREADY    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (M0_ARESETN_I && (r0_cmd_valid || r1_cmd_valid)) begin
`ifdef SOC_M0_ARB_FIXED_PRIO_EN
                    win = !r0_cmd_valid;
`else
                    win = (r0_cmd_valid && r1_cmd_valid) ? !rr_last_q : !r0_cmd_valid;
                    rr_last_d = win;
`endif
                    r0_cmd_ready = !win;
                    r1_cmd_ready = win;
                    write_d = win ? r1_cmd_write : r0_cmd_write;
                    addr_d  = win ? r1_cmd_addr  : r0_cmd_addr;
                    len_d   = win ? r1_cmd_len   : r0_cmd_len;
                    grant_d = win;
                    cnt_d   = '0;
                    racc_d  = '0;
                    rerr_d  = 1'b0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                M0_AWVALID = write_q;
                M0_ARVALID = !write_q;
                if (write_q && M0_AWREADY) begin
                    state_d = WDATA;
                end else if (!write_q && M0_ARREADY) begin
                    state_d = RDATA;
                end
            end
            WDATA: begin
                M0_WVALID   = grant_q ? r1_wr_valid : r0_wr_valid;
                M0_WDATA    = grant_q ? r1_wr_data  : r0_wr_data;
                M0_WSTRB    = grant_q ? r1_wr_strb  : r0_wr_strb;
                M0_WLAST    = (cnt_q == len_q);
                r0_wr_ready = !grant_q && M0_WREADY;
                r1_wr_ready = grant_q && M0_WREADY;
                if (M0_WVALID && M0_WREADY) begin
                    cnt_d = cnt_q + 3'd1;
                    if (M0_WLAST) begin
                        state_d = BRESP;
                    end
                end
            end
            BRESP: begin
                M0_BREADY = 1'b1;
                if (M0_BVALID) begin
                    fin      = 1'b1;
                    fin_resp = (M0_BID != {3'b000, grant_q}) ? 2'b10 : M0_BRESP;
                    state_d  = IDLE;
                end
            end
            RDATA: begin
                M0_RREADY   = grant_q ? r1_rd_ready : r0_rd_ready;
                r0_rd_valid = !grant_q && M0_RVALID;
                r1_rd_valid = grant_q && M0_RVALID;
                r0_rd_data  = grant_q ? '0 : M0_RDATA;
                r1_rd_data  = grant_q ? M0_RDATA : '0;
                r0_rd_last  = !grant_q && M0_RLAST;
                r1_rd_last  = grant_q && M0_RLAST;
                if (M0_RVALID && M0_RREADY) begin
                    // Worst response seen so far, with an ID mismatch overriding to SLVERR
                    rresp_max = (M0_RRESP > racc_q) ? M0_RRESP : racc_q;
                    rid_bad   = rerr_q || (M0_RID != {3'b000, grant_q});
                    racc_d    = rresp_max;
                    rerr_d    = rid_bad;
                    if (M0_RLAST) begin
                        fin      = 1'b1;
                        fin_resp = rid_bad ? 2'b10 : rresp_max;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            done_d[grant_q] = 1'b1;
            if (grant_q) begin
                resp1_d = fin_resp;
            end else begin
                resp0_d = fin_resp;
            end
        end
    end
endmodule
